// File: rtl/ads_uart_pkg.sv
// Shared FSM encoding, ASCII constants and nibble-to-hex helper for the ADS1115 UART framer.
// ADS_UART_CRLF_EN selects a CR LF terminator; otherwise frames end with LF only.
package ads_uart_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;
  localparam logic [1:0] ST_WAIT_HI = 2'd3;

  typedef logic [7:0] ascii_t;

  localparam ascii_t ASCII_CR   = 8'h0D;
  localparam ascii_t ASCII_LF   = 8'h0A;
  localparam ascii_t ASCII_ZERO = 8'h30;
  localparam ascii_t ASCII_A    = 8'h41;

`ifdef ADS_UART_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif

  function automatic ascii_t nibble_to_ascii(input logic [3:0] nib);
    ascii_t res;
    if (nib < 4'd10) res = ASCII_ZERO + ascii_t'(nib);
    else             res = ASCII_A + ascii_t'(nib) - 8'd10;
    return res;
  endfunction

endpackage

// File: rtl/ads_uart_framer_sample_fifo.sv
// Synchronous sample FIFO, write-first visibility next cycle, combinational read of the head entry.
// Writes while full and reads while empty are ignored; pointers carry an extra wrap bit.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       n_rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count  = wr_ptr - rd_ptr;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ads_uart_framer.sv
// Buffers ADS1115 samples and emits each as an ASCII hex frame to uart_tx; first tx_en two edges after pop.
// Samples arriving while the FIFO is full are dropped and counted; ADS_UART_CRLF_EN selects the CR LF terminator.
module ads_uart_framer
  import ads_uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              tx_ready,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int DIGITS    = DATA_W / 4;
  localparam int FRAME_LEN = DIGITS + TERM_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] DIGITS_IDX = IDX_W'(DIGITS);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;
  ascii_t            cur_byte;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_nxt;
  logic              push;
  logic              pop;

  // No pass-through: a full FIFO refuses the push even on a popping cycle.
  assign push         = sample_valid && !fifo_full;
  assign pop          = (state == ST_IDLE) && !fifo_empty;
  assign sample_ready = !fifo_full;
  assign count_nxt    = fifo_count + CNT_W'(push) - CNT_W'(pop);

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .wr_en  (push),
    .wr_dat (sample_in),
    .rd_en  (pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // The shift register moves one nibble per byte, so the current digit is always the top nibble.
  always_comb begin
    cur_byte = ASCII_LF;
    if (byte_idx < DIGITS_IDX) cur_byte = nibble_to_ascii(shreg[DATA_W-1 -: 4]);
`ifdef ADS_UART_CRLF_EN
    else if (byte_idx == DIGITS_IDX) cur_byte = ASCII_CR;
`endif
  end

  // WAIT_LO guards against uart_tx holding ready_out high for a cycle after accepting a byte.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) state_nxt = ST_SEND;
      ST_SEND:    if (tx_ready)    state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!tx_ready)   state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_ready)    state_nxt = (byte_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      tx_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= fifo_rd_dat;
            byte_idx <= '0;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_en   <= 1'b1;
            tx_data <= cur_byte;
          end
        end
        ST_WAIT_HI: begin
          if (tx_ready && (byte_idx != LAST_IDX)) begin
            byte_idx <= byte_idx + 1'b1;
            shreg    <= shreg << 4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      drop_cnt <= 8'd0;
    end else if (sample_valid && fifo_full && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ads_uart_framer.sv
// Directed bench for ads_uart_framer with a behavioural uart_tx handshake model.
// Honours ADS_UART_CRLF_EN for the expected terminator.
module tb_ads_uart_framer;

  localparam int BYTE_CYC = 8;
`ifdef ADS_UART_CRLF_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif

  logic        clk_in = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] sample_in = 16'h0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        tx_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  // 0: uart_tx-like, 1: ready stuck low, 2: ready stuck high
  int mode = 0;
  int u_cnt;
  logic prev_en;
  int dbl_en;
  logic [7:0] cap_q[$];

  ads_uart_framer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk_in       (clk_in),
    .n_rst        (n_rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .tx_ready     (tx_ready),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  // uart_tx keeps ready high one cycle after accepting, then low for BYTE_CYC cycles.
  always_comb tx_ready = (mode == 2) || ((mode == 0) && ((u_cnt == 0) || (u_cnt == BYTE_CYC + 1)));

  always @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      u_cnt   <= 0;
      prev_en <= 1'b0;
      dbl_en  <= 0;
    end else begin
      prev_en <= tx_en;
      if (tx_en) cap_q.push_back(tx_data);
      if (tx_en && prev_en) dbl_en <= dbl_en + 1;
      if (tx_en && u_cnt == 0) u_cnt <= BYTE_CYC + 1;
      else if (u_cnt != 0) u_cnt <= u_cnt - 1;
    end
  end

  function automatic logic [7:0] exp_byte(input logic [15:0] v, input int i);
    logic [3:0] n;
    if (i < 4) begin
      n = v[15 - 4*i -: 4];
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    end
`ifdef ADS_UART_CRLF_EN
    if (i == 4) return 8'h0D;
`endif
    return 8'h0A;
  endfunction

  task automatic do_reset();
    sample_valid = 1'b0;
    mode = 0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk_in);
    n_rst = 1'b1;
    @(negedge clk_in);
    cap_q.delete();
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk_in);
    sample_in = v;
    sample_valid = 1'b1;
    @(negedge clk_in);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int n, input int limit, output bit timeout, output bit early);
    timeout = 1'b1;
    early = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_in);
      if (!busy && cap_q.size() < n) early = 1'b1;
      if (cap_q.size() >= n && !busy) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single_frame();
    bit to, early;
    logic [7:0] lit [4] = '{8'h41, 8'h35, 8'h46, 8'h30};
    push(16'hA5F0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", busy); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL lat_k: got %b want 0", tx_en); end
    @(negedge clk_in);
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL lat_k1: got %b want 0", tx_en); end
    @(negedge clk_in);
    total++; if (tx_en !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL lat_k2: got en=%b data=%h want en=1 data=41", tx_en, tx_data); end
    @(negedge clk_in);
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL en_pulse: got %b want 0", tx_en); end
    wait_idle(FL, 2000, to, early);
    total++; if (to) begin bad++; $display("FAIL single_timeout: got %0d bytes want %0d", cap_q.size(), FL); end
    total++; if (cap_q.size() != FL) begin bad++; $display("FAIL single_count: got %0d want %0d", cap_q.size(), FL); end
    for (int i = 0; i < FL && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== ((i < 4) ? lit[i] : exp_byte(16'hA5F0, i))) begin
        bad++; $display("FAIL single_byte%0d: got %h want %h", i, cap_q[i], (i < 4) ? lit[i] : exp_byte(16'hA5F0, i));
      end
    end
    total++; if (dbl_en != 0) begin bad++; $display("FAIL single_dbl_en: got %0d want 0", dbl_en); end
  endtask

  task automatic test_back_to_back();
    bit to, early;
    cap_q.delete();
    @(negedge clk_in);
    sample_in = 16'h0000; sample_valid = 1'b1;
    @(negedge clk_in);
    sample_in = 16'hFFFF;
    @(negedge clk_in);
    sample_valid = 1'b0;
    wait_idle(2*FL, 3000, to, early);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: got %0d bytes want %0d", cap_q.size(), 2*FL); end
    total++; if (early) begin bad++; $display("FAIL b2b_busy_early: got busy=0 before last terminator want busy=1"); end
    total++; if (cap_q.size() != 2*FL) begin bad++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), 2*FL); end
    for (int i = 0; i < 2*FL && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== ((i < FL) ? exp_byte(16'h0000, i) : exp_byte(16'hFFFF, i - FL))) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, cap_q[i], (i < FL) ? exp_byte(16'h0000, i) : exp_byte(16'hFFFF, i - FL));
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full_drop();
    bit to, early;
    logic [15:0] exp_v;
    do_reset();
    mode = 1;
    push(16'h0ACE);
    repeat (2) @(negedge clk_in);
    sample_in = 16'h9AB0; sample_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_in);
      if (i == 3) begin
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL full_ready3: got %b want 1", sample_ready); end
      end
      if (i == 4) begin
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL full_ready4: got %b want 0", sample_ready); end
      end
      if (i < 7) sample_in = 16'h9AB0 + 16'(i);
      else sample_valid = 1'b0;
    end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL full_drop_cnt: got %0d want 3", drop_cnt); end
    total++; if (cap_q.size() != 0) begin bad++; $display("FAIL full_no_send: got %0d bytes want 0", cap_q.size()); end
    mode = 0;
    wait_idle(5*FL, 6000, to, early);
    total++; if (to) begin bad++; $display("FAIL full_timeout: got %0d bytes want %0d", cap_q.size(), 5*FL); end
    total++; if (cap_q.size() != 5*FL) begin bad++; $display("FAIL full_count: got %0d want %0d", cap_q.size(), 5*FL); end
    for (int i = 0; i < 5*FL && i < cap_q.size(); i++) begin
      exp_v = (i < FL) ? 16'h0ACE : (16'h9AB0 + 16'(i/FL - 1));
      total++;
      if (cap_q[i] !== exp_byte(exp_v, i % FL)) begin
        bad++; $display("FAIL full_byte%0d: got %h want %h", i, cap_q[i], exp_byte(exp_v, i % FL));
      end
    end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL full_ready_end: got %b want 1", sample_ready); end
  endtask

  task automatic test_stuck_high();
    do_reset();
    mode = 2;
    push(16'h1111);
    repeat (40) @(negedge clk_in);
    total++; if (cap_q.size() != 1) begin bad++; $display("FAIL stuck_count: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      total++; if (cap_q[0] !== 8'h31) begin bad++; $display("FAIL stuck_byte: got %h want 31", cap_q[0]); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stuck_busy: got %b want 1", busy); end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    bit to, early, hit;
    do_reset();
    push(16'hBEEF);
    push(16'h5555);
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_in);
      if (cap_q.size() >= 2) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_wait: got %0d bytes want 2", cap_q.size()); end
    n_rst = 1'b0;
    @(negedge clk_in);
    total++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_tx: got en=%b data=%h want en=0 data=00", tx_en, tx_data); end
    total++; if (busy !== 1'b0 || sample_ready !== 1'b1 || drop_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_rst_status: got busy=%b ready=%b drop=%0d want 0 1 0", busy, sample_ready, drop_cnt);
    end
    @(negedge clk_in);
    n_rst = 1'b1;
    @(negedge clk_in);
    cap_q.delete();
    push(16'h1234);
    wait_idle(FL, 2000, to, early);
    total++; if (to) begin bad++; $display("FAIL mid_timeout: got %0d bytes want %0d", cap_q.size(), FL); end
    total++; if (cap_q.size() != FL) begin bad++; $display("FAIL mid_count: got %0d want %0d", cap_q.size(), FL); end
    for (int i = 0; i < FL && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(16'h1234, i)) begin
        bad++; $display("FAIL mid_byte%0d: got %h want %h", i, cap_q[i], exp_byte(16'h1234, i));
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 1;
    push(16'h0001);
    repeat (2) @(negedge clk_in);
    sample_in = 16'h2222; sample_valid = 1'b1;
    repeat (204) @(negedge clk_in);
    total++; if (drop_cnt !== 8'd200) begin bad++; $display("FAIL sat_mid: got %0d want 200", drop_cnt); end
    repeat (100) @(negedge clk_in);
    sample_valid = 1'b0;
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_end: got %0d want 255", drop_cnt); end
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL sat_ready: got %b want 0", sample_ready); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_drop();
    test_stuck_high();
    test_reset_mid_frame();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
